// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. The asynchronous serial line is brought into the clk
//   domain through a two-flop synchronizer. A small FSM then samples each bit
//   near its centre. Each correctly framed byte is presented on rx_data
//   together with a one-cycle valid strobe.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst            in   1  synchronous, active-high reset
//   serial_data_in in   1  asynchronous serial line, idles high
//   rx_data        out  8  last byte received with a valid stop bit
//   rx_valid       out  1  one-cycle pulse when rx_data is updated
//   rx_frame_err   out  1  one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shift, shift_n;
    logic [7:0]        data_n;
    logic              valid_n;
    logic              ferr_n;

    logic              sync_p0;
    logic              rx_s;

    // Synchronizer stage: flops reset to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_p0 <= serial_data_in;
            rx_s    <= sync_p0;
        end
    end

    // Registered FSM state, counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                end
            end

            START: begin
                // Re-check the line at mid start bit; a high level here was
                // only a glitch and produces no output activity.
                if (cnt == HALF_END) begin
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt == BIT_END) begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n            = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end

            STOP: begin
                // Leave at mid stop bit so that a start bit directly after
                // the stop bit is still seen from IDLE.
                if (cnt == BIT_END) begin
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end

            BREAK: begin
                // A line held low must return high before a new frame can start.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n != state) begin
            cnt_n = '0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT = 434;

    logic       clk;
    logic       rst;
    logic       serial_data_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int valid_cyc = 0;
    int fall_cyc = 0;

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .BAUD_RATE(115_200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_data_in(serial_data_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (rx_frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (rx_valid === 1'b1 && rx_frame_err === 1'b1) n_both = n_both + 1;
    end

    task automatic idle(input int n);
        serial_data_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        serial_data_in = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        serial_data_in = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid);
        end
        checks++;
        if (rx_frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL post_reset_data: got %h expected 00", rx_data);
        end
        checks++;
        if (n_valid !== 0) begin
            errors++; $display("FAIL post_reset_valid_count: got %0d expected 0", n_valid);
        end
        checks++;
        if (n_ferr !== 0) begin
            errors++; $display("FAIL post_reset_ferr_count: got %0d expected 0", n_ferr);
        end
    endtask

    task automatic test_single_byte;
        int v0;
        int lat;
        v0 = n_valid;
        send_byte(8'h37, 1'b1);
        idle(10);
        checks++;
        if (rx_data !== 8'h37) begin
            errors++; $display("FAIL single_data: got %h expected 37", rx_data);
        end
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0);
        end
        // 2 sync + 1 detect + 217 start + 9*434 data/stop = 4126 cycles
        lat = valid_cyc - fall_cyc;
        checks++;
        if (lat < 4121 || lat > 4131) begin
            errors++; $display("FAIL single_latency: got %0d expected 4126 +/-5", lat);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_byte(8'h37, 1'b1);
        checks++;
        if (rx_data !== 8'h37) begin
            errors++; $display("FAIL b2b_data0: got %h expected 37", rx_data);
        end
        idle(1);
        send_byte(8'hFF, 1'b1);
        checks++;
        if (rx_data !== 8'hFF) begin
            errors++; $display("FAIL b2b_data1: got %h expected FF", rx_data);
        end
        send_byte(8'h00, 1'b1);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL b2b_data2: got %h expected 00", rx_data);
        end
        send_byte(8'hA5, 1'b1);
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++; $display("FAIL b2b_data3: got %h expected A5", rx_data);
        end
        idle(20);
        checks++;
        if (n_valid - v0 !== 4) begin
            errors++; $display("FAIL b2b_valid_count: got %0d expected 4", n_valid - v0);
        end
    endtask

    task automatic test_glitch;
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        serial_data_in = 1'b0;
        repeat (100) @(negedge clk);
        idle(600);
        checks++;
        if (n_valid - v0 !== 0) begin
            errors++; $display("FAIL glitch_valid_count: got %0d expected 0", n_valid - v0);
        end
        checks++;
        if (n_ferr - f0 !== 0) begin
            errors++; $display("FAIL glitch_ferr_count: got %0d expected 0", n_ferr - f0);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++; $display("FAIL glitch_data_hold: got %h expected A5", rx_data);
        end
        send_byte(8'h5A, 1'b1);
        idle(10);
        checks++;
        if (rx_data !== 8'h5A || n_valid - v0 !== 1) begin
            errors++; $display("FAIL glitch_next_byte: got %h/%0d expected 5A/1", rx_data, n_valid - v0);
        end
    endtask

    task automatic test_frame_err;
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'hC3, 1'b0);
        serial_data_in = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        idle(50);
        checks++;
        if (n_ferr - f0 !== 1) begin
            errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0);
        end
        checks++;
        if (n_valid - v0 !== 0) begin
            errors++; $display("FAIL ferr_valid_count: got %0d expected 0", n_valid - v0);
        end
        checks++;
        if (rx_data !== 8'h5A) begin
            errors++; $display("FAIL ferr_data_hold: got %h expected 5A", rx_data);
        end
        send_byte(8'h3C, 1'b1);
        idle(10);
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++; $display("FAIL ferr_next_data: got %h expected 3C", rx_data);
        end
        checks++;
        if (n_valid - v0 !== 1 || n_ferr - f0 !== 1) begin
            errors++; $display("FAIL ferr_next_counts: got %0d/%0d expected 1/1", n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        int f0;
        logic [7:0] b;
        b = 8'h96;
        v0 = n_valid;
        f0 = n_ferr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        serial_data_in = b[4];
        repeat (200) @(negedge clk);
        rst = 1'b1;
        serial_data_in = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        idle(2 * 10 * BIT);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_data: got %h expected 00", rx_data);
        end
        checks++;
        if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin
            errors++; $display("FAIL midrst_pulses: got %0d/%0d expected 0/0", n_valid - v0, n_ferr - f0);
        end
        send_byte(8'h96, 1'b1);
        idle(10);
        checks++;
        if (rx_data !== 8'h96) begin
            errors++; $display("FAIL midrst_resend_data: got %h expected 96", rx_data);
        end
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++; $display("FAIL midrst_resend_count: got %0d expected 1", n_valid - v0);
        end
    endtask

    initial begin
        rst = 1'b1;
        serial_data_in = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid_frame;
        checks++;
        if (n_both !== 0) begin
            errors++; $display("FAIL valid_and_ferr_same_cycle: got %0d expected 0", n_both);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
